// File: rtl/mod_counter.sv
// Parametrised modulo counter: programmable terminal value, up/down, load,
// synchronous clear and a one-shot pass FSM with start/busy/done handshake.
module mod_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_dn,
    input  logic             cnt_en,
    input  logic             mode,
    input  logic             start,
    output logic [WIDTH-1:0] d_out,
    output logic             tc,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] count_val;
    logic             wrap_nxt;
    logic             done_nxt;

    // Counting up past limit (limit lowered mid-count) is terminal too.
    assign tc = up_dn ? (d_out >= limit) : (d_out == '0);

    always_comb begin
        if (up_dn) count_val = tc ? '0    : d_out + ONE;
        else       count_val = tc ? limit : d_out - ONE;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = d_out;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (clr) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if (load) begin
            cnt_nxt = load_val;
        end else if (!mode) begin
            // Leaving one-shot mode drops RUN silently, no done pulse.
            state_nxt = IDLE;
            if (cnt_en) begin
                cnt_nxt  = count_val;
                wrap_nxt = tc;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_nxt   = up_dn ? '0 : limit;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (cnt_en) begin
                        if (tc) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = count_val;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            d_out <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            d_out <= cnt_nxt;
            wrap  <= wrap_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule
